// File: rtl/fetch_sequencer_pkg.sv
// Shared opcodes, instruction field helpers and fetch state encoding for fetch_sequencer.
package fetch_sequencer_pkg;

  localparam logic [5:0] OP_JMP  = 6'h02;
  localparam logic [5:0] OP_HALT = 6'h3F;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_HALT,
    ST_FAULT
  } fetch_state_e;

  function automatic logic [5:0] opcode(input logic [31:0] word);
    return word[31:26];
  endfunction

  // Jump keeps the upper six pc bits and replaces the low 26 with the jump field.
  function automatic logic [31:0] jump_target(input logic [31:0] pc, input logic [31:0] word);
    return {pc[31:26], word[25:0]};
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory, redirect and decode-handshake signals of fetch_sequencer.
interface fetch_sequencer_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  modport master (
    output imem_addr, out_valid, out_pc, out_instr,
    input  imem_instr, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_addr, out_valid, out_pc, out_instr,
    output imem_instr, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_sequencer_pc_next_sel.sv
// Combinational next-pc / next-state / output-register control for fetch_sequencer.
module pc_next_sel
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = 11
) (
  input  fetch_state_e state,
  input  logic [31:0]  pc,
  input  logic         fetch_en,
  input  logic         out_valid,
  input  logic         out_ready,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  input  logic [31:0]  imem_instr,
  output logic [31:0]  pc_next,
  output fetch_state_e state_next,
  output logic         valid_next,
  output logic         load_out,
  output logic         fold_jmp
);

  logic slot_free;
  logic fire;

  assign slot_free = !out_valid || out_ready;
  assign fire      = (state == ST_RUN) && fetch_en && slot_free;

  always_comb begin
    pc_next    = pc;
    state_next = state;
    valid_next = out_valid && !out_ready;
    load_out   = 1'b0;
    fold_jmp   = 1'b0;
    if (redirect_valid) begin
      pc_next    = redirect_pc;
      state_next = ST_RUN;
      valid_next = 1'b0;
    end else if (fire) begin
      if (pc >= IMEM_DEPTH) begin
        state_next = ST_FAULT;
      end else begin
        case (opcode(imem_instr))
          OP_JMP: begin
            pc_next  = jump_target(pc, imem_instr);
            fold_jmp = 1'b1;
          end
          OP_HALT: begin
            load_out   = 1'b1;
            valid_next = 1'b1;
            state_next = ST_HALT;
          end
          default: begin
            load_out   = 1'b1;
            valid_next = 1'b1;
            pc_next    = pc + 32'd1;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns pc, folds JMP, stops on HALT/fault, feeds decode.
// Optional FETCH_PERF_EN adds a saturating folded-JMP counter on jmp_count.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int unsigned IMEM_DEPTH = 11
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                fetch_en,
  fetch_sequencer_if.master   bus,
  output logic                halted,
  output logic                fault,
  output logic [15:0]         jmp_count
);

  fetch_state_e state, state_next;
  logic [31:0]  pc, pc_next;
  logic         valid_next;
  logic         load_out;
  logic         fold_jmp;

  pc_next_sel #(
    .IMEM_DEPTH(IMEM_DEPTH)
  ) u_pc_next_sel (
    .state          (state),
    .pc             (pc),
    .fetch_en       (fetch_en),
    .out_valid      (bus.out_valid),
    .out_ready      (bus.out_ready),
    .redirect_valid (bus.redirect_valid),
    .redirect_pc    (bus.redirect_pc),
    .imem_instr     (bus.imem_instr),
    .pc_next        (pc_next),
    .state_next     (state_next),
    .valid_next     (valid_next),
    .load_out       (load_out),
    .fold_jmp       (fold_jmp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
      pc    <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_pc    <= '0;
      bus.out_instr <= '0;
    end else begin
      bus.out_valid <= valid_next;
      if (load_out) begin
        bus.out_pc    <= pc;
        bus.out_instr <= bus.imem_instr;
      end
    end
  end

  assign bus.imem_addr = pc;
  assign halted        = (state == ST_HALT);
  assign fault         = (state == ST_FAULT);

`ifdef FETCH_PERF_EN
  logic [15:0] jmp_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      jmp_cnt <= '0;
    end else if (fold_jmp && (jmp_cnt != '1)) begin
      jmp_cnt <= jmp_cnt + 16'd1;
    end
  end

  assign jmp_count = jmp_cnt;
`else
  logic unused_fold;
  assign unused_fold = fold_jmp;
  assign jmp_count   = '0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a program-level reference walk predicts deliveries.
module tb_fetch_sequencer;
  import fetch_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic        halted;
  logic        fault;
  logic [15:0] jmp_count;

  fetch_sequencer_if bus ();

  fetch_sequencer #(
    .RESET_PC   (32'h0),
    .IMEM_DEPTH (11)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .fetch_en  (fetch_en),
    .bus       (bus),
    .halted    (halted),
    .fault     (fault),
    .jmp_count (jmp_count)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [16];
  assign bus.imem_instr = (bus.imem_addr < 32'd16) ? mem[bus.imem_addr[3:0]] : 32'hDEADBEEF;

  int          tests = 0;
  int          fails = 0;
  logic [63:0] exp_q [$];
  int          exp_term;     // 1 = ends in HALT, 2 = ends in fault
  logic [31:0] exp_stop;
  int unsigned jmps = 0;
  logic [63:0] mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_jc();
`ifdef FETCH_PERF_EN
    return (jmps > 32'd65535) ? 32'h0000FFFF : jmps;
`else
    return 32'h0;
`endif
  endfunction

  function automatic logic [31:0] add_word();
    logic [31:0] w;
    logic [31:0] op;
    w  = $urandom;
    op = $urandom_range(3, 62);
    w[31:26] = op[5:0];
    return w;
  endfunction

  // Reference: walk the program from start, recording what decode must see and where it stops.
  task automatic predict(input logic [31:0] start);
    logic [31:0] p;
    logic [31:0] w;
    p = start;
    exp_term = 0;
    for (int unsigned steps = 0; steps < 64; steps++) begin
      if (p >= 32'd11) begin
        exp_term = 2;
        exp_stop = p;
        return;
      end
      w = mem[p[3:0]];
      if (w[31:26] == OP_JMP) begin
        p = {p[31:26], w[25:0]};
        jmps++;
      end else if (w[31:26] == OP_HALT) begin
        exp_q.push_back({p, w});
        exp_term = 1;
        exp_stop = p;
        return;
      end else begin
        exp_q.push_back({p, w});
        p = p + 32'd1;
      end
    end
  endtask

  task automatic redirect_to(input logic [31:0] target, input bit do_predict);
    @(posedge clk); #1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = target;
    @(posedge clk); #1;
    bus.redirect_valid = 1'b0;
    if (do_predict) predict(target);
  endtask

  task automatic wait_done(input bit rnd);
    int cyc;
    cyc = 0;
    while (!(exp_q.size() == 0 &&
             ((exp_term == 1 && halted === 1'b1) || (exp_term == 2 && fault === 1'b1)))
           && cyc < 600) begin
      @(posedge clk); #1;
      if (rnd) begin
        fetch_en      = ($urandom_range(0, 3) != 0);
        bus.out_ready = ($urandom_range(0, 2) != 0);
      end
      cyc++;
    end
    check("finished_in_budget", (cyc < 600), 1);
    fetch_en      = 1'b1;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("end_out_valid", bus.out_valid, 0);
    check("end_halted", halted, (exp_term == 1));
    check("end_fault", fault, (exp_term == 2));
    check("end_imem_addr", bus.imem_addr, exp_stop);
    check("end_jmp_count", jmp_count, exp_jc());
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_delivery: got pc %h instr %h expected nothing", bus.out_pc, bus.out_instr);
      end else begin
        mon_e = exp_q.pop_front();
        check("deliver_pc", bus.out_pc, mon_e[63:32]);
        check("deliver_instr", bus.out_instr, mon_e[31:0]);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d failed so far", fails);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned r;
    int unsigned t;
    rst_n              = 1'b0;
    fetch_en           = 1'b1;
    bus.out_ready      = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    for (int i = 0; i < 16; i++) mem[i] = add_word();
    mem[4] = 32'hFC000000;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_pc", bus.out_pc, 0);
    check("rst_out_instr", bus.out_instr, 0);
    check("rst_halted", halted, 0);
    check("rst_fault", fault, 0);
    check("rst_jmp_count", jmp_count, 0);
    check("rst_imem_addr", bus.imem_addr, 0);

    // Straight-line run 0..3 then HALT at 4, one instruction per cycle
    @(posedge clk); #1;
    predict(32'h0);
    rst_n = 1'b1;
    for (int unsigned k = 0; k < 5; k++) begin
      @(posedge clk); @(negedge clk);
      check("stream_valid", bus.out_valid, 1);
      check("stream_pc", bus.out_pc, k);
    end
    wait_done(0);

    // Backpressure at out_pc=2 for three cycles
    redirect_to(32'h0, 1);
    check("halt_cleared_by_redirect", halted, 0);
    repeat (3) @(posedge clk);
    #1 bus.out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("bp_valid", bus.out_valid, 1);
      check("bp_pc", bus.out_pc, 2);
      check("bp_instr", bus.out_instr, mem[2]);
      check("bp_imem_addr", bus.imem_addr, 3);
      @(posedge clk);
    end
    #1 bus.out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); @(negedge clk);
    check("bp_resume_pc", bus.out_pc, 3);
    wait_done(0);

    // JMP folded at pc 1 -> bubble -> pc 5
    mem[1] = 32'h08000005;
    mem[6] = 32'hFC000000;
    redirect_to(32'h0, 1);
    @(posedge clk); @(negedge clk);
    check("jmp_first_pc", bus.out_pc, 0);
    @(posedge clk); @(negedge clk);
    check("jmp_bubble", bus.out_valid, 0);
    @(posedge clk); @(negedge clk);
    check("jmp_target_valid", bus.out_valid, 1);
    check("jmp_target_pc", bus.out_pc, 5);
    wait_done(0);

    // Run off the end of memory: 8,9,10 then fault at 11
    for (int i = 8; i < 11; i++) mem[i] = add_word();
    redirect_to(32'h8, 1);
    wait_done(0);

    // Flush an unaccepted output while a JMP sits on imem_instr
    bus.out_ready = 1'b0;
    redirect_to(32'h0, 0);
    check("fault_cleared_by_redirect", fault, 0);
    @(posedge clk); #1;
    check("flush_pre_valid", bus.out_valid, 1);
    check("flush_pre_imem_addr", bus.imem_addr, 1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8;
    @(posedge clk); #1;
    bus.redirect_valid = 1'b0;
    predict(32'h8);
    @(negedge clk);
    check("flush_valid", bus.out_valid, 0);
    check("flush_imem_addr", bus.imem_addr, 8);
    check("flush_jmp_count", jmp_count, exp_jc());
    bus.out_ready = 1'b1;
    wait_done(0);

    // Randomized programs: forward-only jumps guarantee every walk ends in HALT or fault
    for (int ep = 0; ep < 30; ep++) begin
      for (int i = 0; i < 16; i++) begin
        r = $urandom_range(0, 99);
        if (i < 13 && r < 15) begin
          t = $urandom_range(i + 1, 13);
          mem[i] = {OP_JMP, t[25:0]};
        end else if (r < 25) begin
          t = $urandom;
          mem[i] = {OP_HALT, t[25:0]};
        end else begin
          mem[i] = add_word();
        end
      end
      redirect_to($urandom_range(0, 12), 1);
      wait_done(1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
